// File: rtl/ifu_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default widths, queue
// depth and the instruction presented to decode when nothing is buffered.
package ifu_fetch_queue_pkg;
    localparam int XLEN      = 32;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_PTR_W  = $clog2(FQ_DEPTH);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'h0000_0004;
endpackage

// File: rtl/ifu_fq_fifo.sv
// Circular buffer of packed {pc, instruction} entries with synchronous clear
// and synchronous active-low reset; a pop on an empty buffer is ignored.
module ifu_fq_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = ifu_fetch_queue_pkg::FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign empty_o     = (count_q == {CNT_W{1'b0}});
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign count_o     = count_q;
    assign head_data_o = mem_q[head_q];

    // Pointer and occupancy next-state; clear wins over push and pop
    always_comb begin
        do_push_s = push_i & ~clear_i;
        do_pop_s  = pop_i & ~clear_i & ~empty_o;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (clear_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                tail_d = tail_q + PTR_W'(1'b1);
            end else begin
                tail_d = tail_q;
            end
            if (do_pop_s) begin
                head_d = head_q + PTR_W'(1'b1);
            end else begin
                head_d = head_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[tail_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch stage with a request/response memory port and a queue of fetched
// {pc, instruction} pairs; responses requested before a flush are discarded.
module ifu_fetch_queue #(
    parameter int              XLEN         = ifu_fetch_queue_pkg::XLEN,
    parameter int              DEPTH        = ifu_fetch_queue_pkg::FQ_DEPTH,
    parameter int              MAX_INFLIGHT = 4,
    parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_flag,
    input  logic [XLEN-1:0]        flush_addr,
    input  logic                   load_hazerd,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [XLEN-1:0]        req_addr,
    input  logic                   rsp_valid,
    input  logic [XLEN-1:0]        rsp_data,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instruction,
    output logic [$clog2(DEPTH):0] fq_count
);
    import ifu_fetch_queue_pkg::*;

    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, fill_pc_q, fill_pc_d;
    logic [IW-1:0]     live_q, live_d, drop_q, drop_d;
    logic              accept_s, push_s, pop_s, room_s, credit_s;
    logic              empty_s, full_s;
    logic [2*XLEN-1:0] head_s;
    logic [CNT_W-1:0]  count_s;

    assign room_s    = (int'(count_s) + int'(live_q)) < DEPTH;
    assign credit_s  = (int'(live_q) + int'(drop_q)) < MAX_INFLIGHT;
    assign req_valid = rst & ~flush_flag & room_s & credit_s;
    assign req_addr  = fetch_pc_q;
    assign accept_s  = req_valid & req_ready;

    assign out_valid       = ~empty_s;
    assign out_pc          = empty_s ? {XLEN{1'b0}} : head_s[2*XLEN-1:XLEN];
    assign out_instruction = empty_s ? XLEN'(NOP_INSTR) : head_s[XLEN-1:0];
    assign fq_count        = count_s;
    assign pop_s           = out_valid & ~load_hazerd & ~flush_flag;

    // Issue, response steering and flush bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        fill_pc_d  = fill_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        push_s     = 1'b0;
        if (flush_flag) begin
            fetch_pc_d = {flush_addr[XLEN-1:2], 2'b00};
            fill_pc_d  = {flush_addr[XLEN-1:2], 2'b00};
            live_d     = {IW{1'b0}};
            // a response landing in the flush cycle retires one outstanding slot
            drop_d     = drop_q + live_q
                       - IW'(rsp_valid & ((drop_q != {IW{1'b0}}) | (live_q != {IW{1'b0}})));
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_valid && (drop_q != {IW{1'b0}})) begin
                drop_d = drop_q - IW'(1'b1);
            end else if (rsp_valid && (live_q != {IW{1'b0}}) && (!full_s || pop_s)) begin
                push_s    = 1'b1;
                fill_pc_d = fill_pc_q + XLEN'(PC_STEP);
            end else begin
                push_s = 1'b0;
            end
            live_d = live_q + IW'(accept_s) - IW'(push_s);
        end
    end

    // Fetch/fill pointers and outstanding-request counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            fill_pc_q  <= RESET_PC;
            live_q     <= {IW{1'b0}};
            drop_q     <= {IW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            fill_pc_q  <= fill_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

    ifu_fq_fifo #(
        .W     (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (rst),
        .clear_i     (flush_flag),
        .push_i      (push_s),
        .push_data_i ({fill_pc_q, rsp_data}),
        .pop_i       (pop_s),
        .head_data_o (head_s),
        .count_o     (count_s),
        .empty_o     (empty_s),
        .full_o      (full_s)
    );
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench: a bench-side memory with configurable latency plus a model
// that tracks each outstanding request as kept or dropped.
module tb_ifu_fetch_queue;
    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam int          MAXI  = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, flush_flag, load_hazerd, req_ready, rsp_valid;
    logic [31:0] flush_addr, rsp_data;
    logic        req_valid, out_valid;
    logic [31:0] req_addr, out_pc, out_instruction;
    logic [2:0]  fq_count;

    ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush_flag(flush_flag), .flush_addr(flush_addr),
        .load_hazerd(load_hazerd), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
        .fq_count(fq_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic keep; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

    req_t        outq[$];
    ent_t        fq[$];
    logic [31:0] m_fetch;
    int          cyc, lat, n_cmp, n_bad, acc_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bench memory: in-order responses, each on its due cycle
    task automatic prep();
        rsp_valid = (outq.size() > 0) && (outq[0].due <= cyc);
        rsp_data  = rsp_valid ? (outq[0].addr ^ KEY) : 32'hDEAD_BEEF;
    endtask

    task automatic peek();
        prep();
        #1;
    endtask

    task automatic cycle(input bit do_cmp);
        bit   exp_rv, rv, pop;
        int   keep_n, due;
        req_t r;
        prep();
        #1;
        rv = rsp_valid;
        keep_n = 0;
        foreach (outq[i]) if (outq[i].keep) keep_n++;
        exp_rv = rst && !flush_flag && (fq.size() + keep_n < DEPTH) && (outq.size() < MAXI);
        if (do_cmp) begin
            chk("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
            if (exp_rv) chk("req_addr", req_addr, m_fetch);
            chk("out_valid", {31'd0, out_valid}, {31'd0, fq.size() > 0});
            chk("out_pc", out_pc, (fq.size() > 0) ? fq[0].pc : 32'h0);
            chk("out_instruction", out_instruction, (fq.size() > 0) ? fq[0].ins : NOP);
            chk("fq_count", {29'd0, fq_count}, fq.size());
        end
        if (req_valid && req_ready) acc_cnt++;
        @(posedge clk);
        if (!rst) begin
            fq.delete();
            outq.delete();
            m_fetch = RPC;
        end else if (flush_flag) begin
            if (rv) void'(outq.pop_front());
            foreach (outq[i]) outq[i].keep = 1'b0;
            fq.delete();
            m_fetch = {flush_addr[31:2], 2'b00};
        end else begin
            pop = (fq.size() > 0) && !load_hazerd;
            if (pop) void'(fq.pop_front());
            if (rv) begin
                r = outq.pop_front();
                if (r.keep) begin
                    if (fq.size() >= DEPTH) begin
                        n_bad++;
                        $display("FAIL overflow: push into full queue (cycle %0d)", cyc);
                    end
                    fq.push_back('{r.addr, r.addr ^ KEY});
                end
            end
            if (exp_rv && req_ready) begin
                due = cyc + lat;
                if (outq.size() > 0 && outq[$].due >= due) due = outq[$].due + 1;
                outq.push_back('{m_fetch, 1'b1, due});
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle(1'b1);
        rst = 1'b1;
    endtask

    task automatic wait_out(input string nm, input int budget, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            peek();
            if (out_valid) seen = 1'b1;
            else cycle(1'b1);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, got no out_valid expected pc %h", nm, exp_pc);
        end else begin
            chk(nm, out_pc, exp_pc);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; lat = 1; acc_cnt = 0; m_fetch = RPC;
        rst = 1'b0; flush_flag = 1'b0; flush_addr = 32'h0; load_hazerd = 1'b0;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0;
        @(negedge clk);
        cycle(1'b0);
        cycle(1'b1);
        peek();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_fq_count", {29'd0, fq_count}, 32'd0);
        chk("reset_out_instr", out_instruction, NOP);
        rst = 1'b1;

        // streaming with 1-cycle memory
        peek();
        chk("s1_first_req_valid", {31'd0, req_valid}, 32'd1);
        chk("s1_first_req_addr", req_addr, 32'h0);
        cycle(1'b1);
        peek();
        chk("s1_second_req_addr", req_addr, 32'h4);
        cycle(1'b1);
        peek();
        chk("s1_first_out_valid", {31'd0, out_valid}, 32'd1);
        chk("s1_first_out_pc", out_pc, 32'h0);
        chk("s1_first_out_instr", out_instruction, 32'hA5A5_0000);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1);
            peek();
            chk("s1_stream_pc", out_pc, 32'(4 * k));
        end

        // stall fills the queue, release drains one per cycle
        do_reset();
        load_hazerd = 1'b1;
        acc_cnt = 0;
        run(12);
        peek();
        chk("s2_accepted", 32'(acc_cnt), 32'd4);
        chk("s2_full_count", {29'd0, fq_count}, 32'd4);
        chk("s2_full_req_valid", {31'd0, req_valid}, 32'd0);
        chk("s2_head_pc", out_pc, 32'h0);
        load_hazerd = 1'b0;
        chk("s2_resume_addr", req_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            peek();
            chk("s2_drain_pc", out_pc, 32'(4 * i));
            cycle(1'b1);
        end
        run(4);

        // flush with 3-cycle memory and requests in flight
        do_reset();
        lat = 3;
        run(8);
        flush_flag = 1'b1; flush_addr = 32'h203;
        cycle(1'b1);
        flush_flag = 1'b0;
        peek();
        chk("s3_flush_req_addr", req_addr, 32'h200);
        wait_out("s3_first_pc", 20, 32'h200);
        run(6);

        // flush coinciding with a response, two requests live
        do_reset();
        lat = 2;
        cycle(1'b1);
        cycle(1'b1);
        req_ready = 1'b0;
        flush_flag = 1'b1; flush_addr = 32'h40;
        cycle(1'b1);
        flush_flag = 1'b0; req_ready = 1'b1;
        peek();
        chk("s4_no_stale_out", {31'd0, out_valid}, 32'd0);
        wait_out("s4_first_pc", 20, 32'h40);
        run(4);

        // two flushes close together with long latency
        lat = 6;
        run(6);
        flush_flag = 1'b1; flush_addr = 32'h100;
        cycle(1'b1);
        flush_flag = 1'b0;
        cycle(1'b1);
        flush_flag = 1'b1; flush_addr = 32'h300;
        cycle(1'b1);
        flush_flag = 1'b0;
        wait_out("s5_first_pc", 60, 32'h300);
        run(6);

        // reset while full
        lat = 2;
        load_hazerd = 1'b1;
        run(12);
        peek();
        chk("s6_full_before_reset", {29'd0, fq_count}, 32'd4);
        do_reset();
        peek();
        chk("s6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_fq_count", {29'd0, fq_count}, 32'd0);
        chk("s6_req_addr", req_addr, RPC);
        load_hazerd = 1'b0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
